// File: rtl/gps_trk_pkg.sv
// Shared types for the tracking correlator bank: default widths, result record, output FSM states.
package gps_trk_pkg;

   localparam int unsigned ACC_W_DEF = 16;
   // Transport width for corr_res_t; channels sign-extend their ACC_W sums into it.
   localparam int unsigned ACC_W_MAX = 32;

   typedef struct packed {
      logic signed [ACC_W_MAX-1:0] ei;
      logic signed [ACC_W_MAX-1:0] eq;
      logic signed [ACC_W_MAX-1:0] pi;
      logic signed [ACC_W_MAX-1:0] pq;
      logic signed [ACC_W_MAX-1:0] li;
      logic signed [ACC_W_MAX-1:0] lq;
   } corr_res_t;

   typedef enum logic [0:0] {
      OUT_IDLE    = 1'b0,
      OUT_PRESENT = 1'b1
   } out_state_t;

endpackage

// File: rtl/corr_channel_accum.sv
// One tracking channel: six saturating +/-1 correlators (E/P/L x I/Q) and the epoch snapshot.
module corr_channel_accum
   import gps_trk_pkg::*;
#(
   parameter int unsigned ACC_W = ACC_W_DEF
) (
   input  logic      clk_i,
   input  logic      rst_i,
   input  logic      sample_valid_i,
   input  logic      enable_i,
   input  logic      data_i,
   input  logic      prn_e_i,
   input  logic      prn_p_i,
   input  logic      prn_l_i,
   input  logic      car_sin_i,
   input  logic      car_cos_i,
   input  logic      epoch_i,
   output corr_res_t snap_o
);

   localparam logic signed [ACC_W-1:0] SAT_POS = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_NEG = {1'b1, {(ACC_W-2){1'b0}}, 1'b1};
   localparam logic signed [ACC_W-1:0] ONE     = {{(ACC_W-1){1'b0}}, 1'b1};
   localparam logic signed [ACC_W-1:0] M_ONE   = {ACC_W{1'b1}};

   logic [5:0]              neg;
   logic                    capture;
   logic signed [ACC_W-1:0] acc_q  [6];
   logic signed [ACC_W-1:0] acc_d  [6];
   logic signed [ACC_W-1:0] snap_q [6];

   // Product sign per correlator; index order EI, EQ, PI, PQ, LI, LQ.
   assign neg = {data_i ^ prn_l_i ^ car_cos_i,
                 data_i ^ prn_l_i ^ car_sin_i,
                 data_i ^ prn_p_i ^ car_cos_i,
                 data_i ^ prn_p_i ^ car_sin_i,
                 data_i ^ prn_e_i ^ car_cos_i,
                 data_i ^ prn_e_i ^ car_sin_i};

   assign capture = sample_valid_i & enable_i & epoch_i;

   // Next accumulator value: clear when disabled, restart on epoch, else saturating step.
   always_comb begin
      for (int unsigned k = 0; k < 6; k++) begin
         acc_d[k] = acc_q[k];
         if (!enable_i) begin
            acc_d[k] = '0;
         end else if (sample_valid_i) begin
            if (epoch_i) begin
               acc_d[k] = neg[k] ? M_ONE : ONE;
            end else if (neg[k]) begin
               if (acc_q[k] != SAT_NEG) acc_d[k] = acc_q[k] - ONE;
            end else begin
               if (acc_q[k] != SAT_POS) acc_d[k] = acc_q[k] + ONE;
            end
         end
      end
   end

   // Accumulator and snapshot registers; snapshot takes the sums before the epoch sample.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int unsigned k = 0; k < 6; k++) begin
            acc_q[k]  <= '0;
            snap_q[k] <= '0;
         end
      end else begin
         for (int unsigned k = 0; k < 6; k++) begin
            acc_q[k] <= acc_d[k];
            if (capture) snap_q[k] <= acc_q[k];
         end
      end
   end

   assign snap_o.ei = ACC_W_MAX'(snap_q[0]);
   assign snap_o.eq = ACC_W_MAX'(snap_q[1]);
   assign snap_o.pi = ACC_W_MAX'(snap_q[2]);
   assign snap_o.pq = ACC_W_MAX'(snap_q[3]);
   assign snap_o.li = ACC_W_MAX'(snap_q[4]);
   assign snap_o.lq = ACC_W_MAX'(snap_q[5]);

endmodule

// File: rtl/tracking_correlator_bank.sv
// Bank of N_CH tracking correlators with a round-robin, ready/valid result stream and sticky overrun flags.
module tracking_correlator_bank
   import gps_trk_pkg::*;
#(
   parameter  int unsigned N_CH  = 4,
   parameter  int unsigned ACC_W = ACC_W_DEF,
   localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    data_in,
   input  logic                    sample_valid,
   input  logic [N_CH-1:0]         ch_enable,
   input  logic [N_CH-1:0]         prn_e,
   input  logic [N_CH-1:0]         prn_p,
   input  logic [N_CH-1:0]         prn_l,
   input  logic [N_CH-1:0]         car_sin,
   input  logic [N_CH-1:0]         car_cos,
   input  logic [N_CH-1:0]         epoch,
   input  logic [N_CH-1:0]         ovr_clr,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [CH_W-1:0]         out_ch,
   output logic signed [ACC_W-1:0] out_ei,
   output logic signed [ACC_W-1:0] out_eq,
   output logic signed [ACC_W-1:0] out_pi,
   output logic signed [ACC_W-1:0] out_pq,
   output logic signed [ACC_W-1:0] out_li,
   output logic signed [ACC_W-1:0] out_lq,
   output logic [N_CH-1:0]         overrun
);

   corr_res_t               snap [N_CH];
   out_state_t              state_q, state_d;
   logic [N_CH-1:0]         pend_q, pend_d;
   logic [N_CH-1:0]         ovr_q, ovr_d;
   logic [N_CH-1:0]         ep_evt, elig, grant;
   logic [CH_W-1:0]         rr_q, pick, cand, out_ch_q;
   logic                    found, load;
   int unsigned             rr_idx;
   logic signed [ACC_W-1:0] res_q [6];

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      corr_channel_accum #(.ACC_W(ACC_W)) u_accum (
         .clk_i          (CLK),
         .rst_i          (RST),
         .sample_valid_i (sample_valid),
         .enable_i       (ch_enable[g]),
         .data_i         (data_in),
         .prn_e_i        (prn_e[g]),
         .prn_p_i        (prn_p[g]),
         .prn_l_i        (prn_l[g]),
         .car_sin_i      (car_sin[g]),
         .car_cos_i      (car_cos[g]),
         .epoch_i        (epoch[g]),
         .snap_o         (snap[g])
      );
   end

   assign ep_evt = {N_CH{sample_valid}} & ch_enable & epoch;
   assign elig   = pend_q & ch_enable;

   // Round-robin search: first eligible channel after the last one served.
   always_comb begin
      found  = 1'b0;
      pick   = '0;
      cand   = '0;
      rr_idx = 0;
      for (int unsigned i = 1; i <= N_CH; i++) begin
         rr_idx = 32'(rr_q) + i;
         if (rr_idx >= N_CH) rr_idx = rr_idx - N_CH;
         cand = CH_W'(rr_idx);
         if (!found && elig[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   // Output FSM: load a result from IDLE, or straight after a handshake when more are pending.
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      case (state_q)
         OUT_IDLE: begin
            if (found) begin
               load    = 1'b1;
               state_d = OUT_PRESENT;
            end
         end
         OUT_PRESENT: begin
            if (out_ready) begin
               if (found) load = 1'b1;
               else       state_d = OUT_IDLE;
            end
         end
         default: state_d = OUT_IDLE;
      endcase
   end

   // Pending and sticky overrun bookkeeping; a new epoch beats a same-cycle grant,
   // and an overrun event beats ovr_clr.
   always_comb begin
      grant  = '0;
      pend_d = pend_q;
      ovr_d  = ovr_q;
      for (int unsigned c = 0; c < N_CH; c++) begin
         grant[c] = load && (pick == CH_W'(c));
         if (grant[c])      pend_d[c] = 1'b0;
         if (ep_evt[c])     pend_d[c] = 1'b1;
         if (!ch_enable[c]) pend_d[c] = 1'b0;
         if (ovr_clr[c])    ovr_d[c]  = 1'b0;
         if (ep_evt[c] && pend_q[c] && !grant[c]) ovr_d[c] = 1'b1;
      end
   end

   // State, pointer and output result registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= OUT_IDLE;
         pend_q   <= '0;
         ovr_q    <= '0;
         rr_q     <= CH_W'(N_CH - 1);
         out_ch_q <= '0;
         for (int unsigned k = 0; k < 6; k++) res_q[k] <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         ovr_q   <= ovr_d;
         if (load) begin
            rr_q     <= pick;
            out_ch_q <= pick;
            res_q[0] <= snap[pick].ei[ACC_W-1:0];
            res_q[1] <= snap[pick].eq[ACC_W-1:0];
            res_q[2] <= snap[pick].pi[ACC_W-1:0];
            res_q[3] <= snap[pick].pq[ACC_W-1:0];
            res_q[4] <= snap[pick].li[ACC_W-1:0];
            res_q[5] <= snap[pick].lq[ACC_W-1:0];
         end
      end
   end

   assign out_valid = (state_q == OUT_PRESENT);
   assign out_ch    = out_ch_q;
   assign out_ei    = res_q[0];
   assign out_eq    = res_q[1];
   assign out_pi    = res_q[2];
   assign out_pq    = res_q[3];
   assign out_li    = res_q[4];
   assign out_lq    = res_q[5];
   assign overrun   = ovr_q;

endmodule

// File: tb/tb_tracking_correlator_bank.sv
// Scoreboard bench for tracking_correlator_bank (N_CH=4, ACC_W=16 plus an ACC_W=8 saturation instance).
module tb_tracking_correlator_bank;

   localparam int unsigned N_CH  = 4;
   localparam int          SAT16 = 32767;

   typedef struct {
      int ch;
      int s [6];
   } exp_t;

   logic CLK = 1'b0;
   logic RST, data_in, sample_valid, out_ready, out_ready8;
   logic [N_CH-1:0] ch_enable, prn_e, prn_p, prn_l, car_sin, car_cos, epoch, ovr_clr;
   logic out_valid, out_valid8;
   logic [1:0] out_ch, out_ch8;
   logic signed [15:0] out_ei, out_eq, out_pi, out_pq, out_li, out_lq;
   logic signed [7:0]  o8_ei, o8_eq, o8_pi, o8_pq, o8_li, o8_lq;
   logic [N_CH-1:0] overrun, overrun8;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb [$];
   exp_t mon_e;
   int   m_acc  [N_CH][6];
   int   m_snap [N_CH][6];
   logic bp, be;

   always #5 CLK = ~CLK;

   tracking_correlator_bank #(.N_CH(4), .ACC_W(16)) dut (
      .CLK(CLK), .RST(RST), .data_in(data_in), .sample_valid(sample_valid),
      .ch_enable(ch_enable), .prn_e(prn_e), .prn_p(prn_p), .prn_l(prn_l),
      .car_sin(car_sin), .car_cos(car_cos), .epoch(epoch), .ovr_clr(ovr_clr),
      .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
      .out_ei(out_ei), .out_eq(out_eq), .out_pi(out_pi), .out_pq(out_pq),
      .out_li(out_li), .out_lq(out_lq), .overrun(overrun)
   );

   tracking_correlator_bank #(.N_CH(4), .ACC_W(8)) dut8 (
      .CLK(CLK), .RST(RST), .data_in(data_in), .sample_valid(sample_valid),
      .ch_enable(ch_enable), .prn_e(prn_e), .prn_p(prn_p), .prn_l(prn_l),
      .car_sin(car_sin), .car_cos(car_cos), .epoch(epoch), .ovr_clr(ovr_clr),
      .out_valid(out_valid8), .out_ready(out_ready8), .out_ch(out_ch8),
      .out_ei(o8_ei), .out_eq(o8_eq), .out_pi(o8_pi), .out_pq(o8_pq),
      .out_li(o8_li), .out_lq(o8_lq), .overrun(overrun8)
   );

   task automatic check_eq(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // One clock cycle of stimulus; the model applies the same cycle's effect on the accumulators.
   task automatic step(input logic sv, input logic d,
                       input logic [N_CH-1:0] pe, pp, pl, cs, cc, ep);
      logic [5:0] ng;
      int         contrib;
      @(posedge CLK);
      #1;
      sample_valid = sv; data_in = d;
      prn_e = pe; prn_p = pp; prn_l = pl; car_sin = cs; car_cos = cc; epoch = ep;
      for (int c = 0; c < N_CH; c++) begin
         ng = {d ^ pl[c] ^ cc[c], d ^ pl[c] ^ cs[c], d ^ pp[c] ^ cc[c],
               d ^ pp[c] ^ cs[c], d ^ pe[c] ^ cc[c], d ^ pe[c] ^ cs[c]};
         for (int k = 0; k < 6; k++) begin
            contrib = ng[k] ? -1 : 1;
            if (!ch_enable[c]) begin
               m_acc[c][k] = 0;
            end else if (sv) begin
               if (ep[c]) begin
                  m_snap[c][k] = m_acc[c][k];
                  m_acc[c][k]  = contrib;
               end else begin
                  m_acc[c][k] = m_acc[c][k] + contrib;
                  if (m_acc[c][k] >  SAT16) m_acc[c][k] =  SAT16;
                  if (m_acc[c][k] < -SAT16) m_acc[c][k] = -SAT16;
               end
            end
         end
      end
   endtask

   task automatic idle();
      step(1'b0, 1'b0, '0, '0, '0, '0, '0, '0);
   endtask

   task automatic rstep(input logic [N_CH-1:0] ep);
      step(1'b1, 1'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
           4'($urandom), 4'($urandom), ep);
   endtask

   task automatic push_res(input int c);
      exp_t e;
      e.ch = c;
      e.s  = m_snap[c];
      sb.push_back(e);
   endtask

   task automatic do_reset();
      RST = 1'b1;
      idle();
      idle();
      RST = 1'b0;
      sb.delete();
      for (int c = 0; c < N_CH; c++)
         for (int k = 0; k < 6; k++) begin
            m_acc[c][k]  = 0;
            m_snap[c][k] = 0;
         end
   endtask

   task automatic drain();
      int n = 0;
      while ((sb.size() != 0 || out_valid) && n < 200) begin
         idle();
         n++;
      end
      check_eq("drain_empty", sb.size(), 0);
   endtask

   // Scoreboard consumer: every accepted result is popped and compared field by field.
   initial begin
      longint got [6];
      forever begin
         @(negedge CLK);
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check_eq("unexpected_result_ch", out_ch, -1);
            end else begin
               mon_e  = sb.pop_front();
               got[0] = out_ei; got[1] = out_eq; got[2] = out_pi;
               got[3] = out_pq; got[4] = out_li; got[5] = out_lq;
               check_eq("res_ch", out_ch, mon_e.ch);
               for (int k = 0; k < 6; k++)
                  check_eq($sformatf("res_sum%0d_ch%0d", k, mon_e.ch), got[k], mon_e.s[k]);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      RST = 1'b1; data_in = 0; sample_valid = 0; ch_enable = '0;
      prn_e = '0; prn_p = '0; prn_l = '0; car_sin = '0; car_cos = '0;
      epoch = '0; ovr_clr = '0; out_ready = 0; out_ready8 = 0;
      do_reset();

      // Reset state
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_out_ch", out_ch, 0);
      check_eq("rst_overrun", overrun, 0);
      check_eq("rst_out_pi", out_pi, 0);
      check_eq("rst_out_lq", out_lq, 0);

      // ch0 all-zero inputs, 1000-sample period, plus T+2 latency
      ch_enable = 4'b0001; out_ready = 1;
      repeat (1000) step(1'b1, 1'b0, '0, '0, '0, '0, '0, '0);
      step(1'b1, 1'b0, '0, '0, '0, '0, '0, 4'b0001);
      push_res(0);
      idle();
      check_eq("lat_t1_valid", out_valid, 0);
      idle();
      check_eq("lat_t2_valid", out_valid, 1);
      check_eq("ch0_pi_1000", out_pi, 1000);
      check_eq("ch0_lq_1000", out_lq, 1000);
      drain();

      // ch1: data = prn_p, prn_l = ~prn_p, carriers 0, N = 500
      do_reset();
      ch_enable = 4'b0010;
      repeat (500) begin
         bp = 1'($urandom); be = 1'($urandom);
         step(1'b1, bp, {2'b0, be, 1'b0}, {2'b0, bp, 1'b0}, {2'b0, ~bp, 1'b0}, '0, '0, '0);
      end
      step(1'b1, 1'b0, '0, '0, 4'b0010, '0, '0, 4'b0010);
      push_res(1);
      idle(); idle();
      check_eq("ch1_out_ch", out_ch, 1);
      check_eq("ch1_pi", out_pi, 500);
      check_eq("ch1_pq", out_pq, 500);
      check_eq("ch1_li", out_li, -500);
      check_eq("ch1_lq", out_lq, -500);
      drain();

      // ACC_W=8 saturation after 300 identical +1 samples
      do_reset();
      ch_enable = 4'b0001;
      repeat (300) step(1'b1, 1'b0, '0, '0, '0, '0, '0, '0);
      step(1'b1, 1'b0, '0, '0, '0, '0, '0, 4'b0001);
      push_res(0);
      idle(); idle();
      check_eq("w8_valid", out_valid8, 1);
      check_eq("w8_ch", out_ch8, 0);
      check_eq("w8_ei", o8_ei, 127);
      check_eq("w8_eq", o8_eq, 127);
      check_eq("w8_pi", o8_pi, 127);
      check_eq("w8_pq", o8_pq, 127);
      check_eq("w8_li", o8_li, 127);
      check_eq("w8_lq", o8_lq, 127);
      check_eq("w16_pi_300", out_pi, 300);
      drain();

      // Simultaneous epochs: back-to-back round-robin service
      do_reset();
      ch_enable = 4'b1111;
      repeat (20) rstep('0);
      rstep(4'b1111);
      push_res(0); push_res(1); push_res(2); push_res(3);
      idle(); idle();
      for (int i = 0; i < 4; i++) begin
         check_eq("b2b_valid", out_valid, 1);
         check_eq("b2b_ch", out_ch, i);
         idle();
      end
      repeat (10) rstep('0);
      rstep(4'b1111);
      push_res(0); push_res(1); push_res(2); push_res(3);
      drain();
      repeat (5) rstep('0);
      rstep(4'b0100);
      push_res(2);
      drain();
      repeat (5) rstep('0);
      rstep(4'b1011);
      push_res(3); push_res(0); push_res(1);
      drain();

      // Overrun on ch2 while ch0 result is stuck unaccepted
      do_reset();
      ch_enable = 4'b0101; out_ready = 0;
      repeat (10) rstep('0);
      rstep(4'b0001);
      push_res(0);
      repeat (7) rstep('0);
      rstep(4'b0100);
      repeat (9) rstep('0);
      rstep(4'b0100);
      push_res(2);
      idle(); idle();
      check_eq("ovr_set", overrun, 4'b0100);
      check_eq("ovr_hold_valid", out_valid, 1);
      check_eq("ovr_hold_ch", out_ch, 0);
      out_ready = 1;
      drain();
      ovr_clr = 4'b0100;
      idle();
      ovr_clr = '0;
      check_eq("ovr_clr", overrun, 0);

      // Overrun event and ovr_clr in the same cycle: set wins
      out_ready = 0;
      rstep(4'b0001);
      push_res(0);
      repeat (4) rstep('0);
      rstep(4'b0100);
      push_res(2);
      repeat (4) rstep('0);
      rstep(4'b0100);
      ovr_clr = 4'b0100;
      void'(sb.pop_back());
      push_res(2);
      idle();
      ovr_clr = '0;
      check_eq("ovr_set_wins", overrun, 4'b0100);
      out_ready = 1;
      drain();

      // Reset while a result is presented
      do_reset();
      ch_enable = 4'b0011; out_ready = 0;
      repeat (5) rstep('0);
      rstep(4'b0001);
      repeat (5) rstep('0);
      rstep(4'b0010);
      repeat (5) rstep('0);
      rstep(4'b0010);
      idle(); idle();
      check_eq("pre_rst_valid", out_valid, 1);
      check_eq("pre_rst_overrun", overrun, 4'b0010);
      RST = 1'b1;
      idle();
      check_eq("mid_rst_valid", out_valid, 0);
      check_eq("mid_rst_overrun", overrun, 0);
      check_eq("mid_rst_ch", out_ch, 0);
      check_eq("mid_rst_ei", out_ei, 0);
      check_eq("mid_rst_pq", out_pq, 0);
      check_eq("mid_rst_lq", out_lq, 0);
      RST = 1'b0;
      sb.delete();
      idle(); idle();
      check_eq("post_rst_valid", out_valid, 0);
      out_ready = 1;
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
